// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and flag bundle for the alu_pipe slice.
package alu_pkg;

   localparam logic [3:0] OP_PASS = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_DIFF = 4'b0100;
   localparam logic [3:0] OP_NEG  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_MUL  = 4'b0111;
   // Any op with this bit set is a shift; lower bits pick source/direction/kind.
   localparam int         OP_SHIFT_MSB = 3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   typedef struct packed {
      logic zero;
      logic sign;
      logic carry;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// done pulses on the WIDTH-th step with the full product presented combinationally.
module alu_pipe_mul
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               r_run;
   logic [2*WIDTH-1:0] w_acc_nxt;

   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign done      = r_run && (r_cnt == CW'(WIDTH - 1));
   assign product   = w_acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (start) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (done) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags. Build with ALU_PIPE_MUL_EN
// defined to get the iterative multiplier on op 0111; otherwise 0111 is pass a.
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             f_zero,
   output logic             f_sign,
   output logic             f_carry,
   output logic             f_ovf,
   output logic             busy
);

   function automatic logic [WIDTH-1:0] f_diff(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] idx;
      idx = WIDTH'(WIDTH);
      for (int i = WIDTH - 1; i >= 0; i--)
         if (x[i]) idx = WIDTH'(i);
      return idx;
   endfunction

   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] x,
                                                input logic [SHW-1:0]   n,
                                                input logic             left,
                                                input logic             logical);
      if (left)         return x << n;
      else if (logical) return x >> n;
      else              return $signed(x) >>> n;
   endfunction

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_result;
   flags_t           r_flags;
   logic             r_out_valid;

   logic             w_accept, w_is_mul, w_mul_done, w_load;
   logic [WIDTH:0]   w_sum, w_dif;
   logic [WIDTH-1:0] w_alu_res, w_ld_res;
   logic             w_alu_carry, w_alu_ovf, w_ld_carry, w_ld_ovf;

   assign w_accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] w_product;

   assign w_is_mul = (op == OP_MUL);

   alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_accept && w_is_mul),
      .a       (a),
      .b       (b),
      .done    (w_mul_done),
      .product (w_product)
   );
`else
   assign w_is_mul   = 1'b0;
   assign w_mul_done = 1'b0;
`endif

   always_comb begin
      w_sum       = {1'b0, a} + {1'b0, b};
      w_dif       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      w_alu_res   = a;
      w_alu_carry = 1'b0;
      w_alu_ovf   = 1'b0;
      if (op[OP_SHIFT_MSB]) begin
         w_alu_res = f_shift(a, op[2] ? b[SHW-1:0] : shamt, op[1], op[0]);
      end else begin
         case (op)
            OP_ADD: begin
               w_alu_res   = w_sum[WIDTH-1:0];
               w_alu_carry = w_sum[WIDTH];
               w_alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
               w_alu_res   = w_dif[WIDTH-1:0];
               w_alu_carry = w_dif[WIDTH];
               w_alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_alu_res = a & b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_DIFF: w_alu_res = f_diff(a ^ b);
            OP_NEG:  w_alu_res = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            default: w_alu_res = a;
         endcase
      end
   end

   // Multiply completion and single-cycle accept are mutually exclusive (in_ready is low in MUL).
   always_comb begin
      w_load     = (w_accept && !w_is_mul) || w_mul_done;
      w_ld_res   = w_alu_res;
      w_ld_carry = w_alu_carry;
      w_ld_ovf   = w_alu_ovf;
`ifdef ALU_PIPE_MUL_EN
      if (w_mul_done) begin
         w_ld_res   = w_product[WIDTH-1:0];
         w_ld_carry = |w_product[2*WIDTH-1:WIDTH];
         w_ld_ovf   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
         ST_MUL:  if (w_mul_done)           w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
`ifdef ALU_PIPE_MUL_EN
      busy     = (r_state == ST_MUL);
`else
      busy     = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_flags     <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_result    <= w_ld_res;
         r_flags     <= '{zero: (w_ld_res == '0), sign: w_ld_res[WIDTH-1],
                          carry: w_ld_carry, ovf: w_ld_ovf};
         r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign f_zero    = r_flags.zero;
   assign f_sign    = r_flags.sign;
   assign f_carry   = r_flags.carry;
   assign f_ovf     = r_flags.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32); multiply expectations
// follow ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0, b = '0;
   logic [3:0]   op = 4'b0000;
   logic [4:0]   shamt = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         f_zero, f_sign, f_carry, f_ovf, busy;

   int nerr = 0;
   int nchk = 0;

   // {out_valid, result, zero, sign, carry, ovf}
   wire [W+4:0] obs = {out_valid, result, f_zero, f_sign, f_carry, f_ovf};

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .f_zero(f_zero), .f_sign(f_sign),
      .f_carry(f_carry), .f_ovf(f_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [4:0] sh);
      in_valid = 1'b1; op = o; a = xa; b = xb; shamt = sh;
   endtask

   task automatic test_reset();
      tick(); tick();
      nchk++; if (obs !== {1'b0, 32'h0, 4'b0000}) begin nerr++; $display("FAIL reset_out: got %h want %h", obs, {1'b0, 32'h0, 4'b0000}); end
      nchk++; if ({in_ready, busy} !== 2'b10) begin nerr++; $display("FAIL reset_rdy_busy: got %b want 10", {in_ready, busy}); end
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_add_sub();
      drive(4'b0001, 32'h7FFF_FFFF, 32'h1, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h8000_0000, 4'b0101}) begin nerr++; $display("FAIL add_ovf: got %h want %h", obs, {1'b1, 32'h8000_0000, 4'b0101}); end
      drive(4'b0110, 32'h1234, 32'h1234, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h0, 4'b1010}) begin nerr++; $display("FAIL sub_equal: got %h want %h", obs, {1'b1, 32'h0, 4'b1010}); end
      drive(4'b0100, 32'h1234, 32'h1234, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'd32, 4'b0000}) begin nerr++; $display("FAIL diff_equal: got %h want %h", obs, {1'b1, 32'd32, 4'b0000}); end
      drive(4'b0100, 32'h10, 32'h30, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'd5, 4'b0000}) begin nerr++; $display("FAIL diff_bit5: got %h want %h", obs, {1'b1, 32'd5, 4'b0000}); end
      drive(4'b0101, 32'h0, 32'h1, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'hFFFF_FFFF, 4'b0100}) begin nerr++; $display("FAIL neg_one: got %h want %h", obs, {1'b1, 32'hFFFF_FFFF, 4'b0100}); end
      drive(4'b0101, 32'h5, 32'h0, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h0, 4'b1000}) begin nerr++; $display("FAIL neg_zero: got %h want %h", obs, {1'b1, 32'h0, 4'b1000}); end
   endtask

   task automatic test_shift();
      drive(4'b1000, 32'h8000_0000, 32'h0, 5'd4); tick();
      nchk++; if (obs !== {1'b1, 32'hF800_0000, 4'b0100}) begin nerr++; $display("FAIL sra_imm: got %h want %h", obs, {1'b1, 32'hF800_0000, 4'b0100}); end
      drive(4'b1001, 32'h8000_0000, 32'h0, 5'd4); tick();
      nchk++; if (obs !== {1'b1, 32'h0800_0000, 4'b0000}) begin nerr++; $display("FAIL srl_imm: got %h want %h", obs, {1'b1, 32'h0800_0000, 4'b0000}); end
      drive(4'b1110, 32'h1, 32'h4, 5'd7); tick();
      nchk++; if (obs !== {1'b1, 32'h10, 4'b0000}) begin nerr++; $display("FAIL sll_reg: got %h want %h", obs, {1'b1, 32'h10, 4'b0000}); end
      drive(4'b1101, 32'h100, 32'h4, 5'd7); tick();
      nchk++; if (obs !== {1'b1, 32'h10, 4'b0000}) begin nerr++; $display("FAIL srl_reg: got %h want %h", obs, {1'b1, 32'h10, 4'b0000}); end
      drive(4'b1010, 32'h3, 32'h7, 5'd31); tick();
      nchk++; if (obs !== {1'b1, 32'h8000_0000, 4'b0100}) begin nerr++; $display("FAIL sll_imm31: got %h want %h", obs, {1'b1, 32'h8000_0000, 4'b0100}); end
   endtask

   task automatic test_back_to_back();
      drive(4'b0001, 32'h1, 32'h1, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h2, 4'b0000}) begin nerr++; $display("FAIL b2b_0: got %h want %h", obs, {1'b1, 32'h2, 4'b0000}); end
      drive(4'b0011, 32'hF0, 32'hFF, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h0F, 4'b0000}) begin nerr++; $display("FAIL b2b_1: got %h want %h", obs, {1'b1, 32'h0F, 4'b0000}); end
      drive(4'b0010, 32'hF0, 32'hFF, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'hF0, 4'b0000}) begin nerr++; $display("FAIL b2b_2: got %h want %h", obs, {1'b1, 32'hF0, 4'b0000}); end
      drive(4'b0000, 32'h0, 32'h9, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h0, 4'b1000}) begin nerr++; $display("FAIL b2b_3: got %h want %h", obs, {1'b1, 32'h0, 4'b1000}); end
      in_valid = 1'b0; tick();
      nchk++; if ({out_valid, in_ready} !== 2'b01) begin nerr++; $display("FAIL b2b_drain: got %b want 01", {out_valid, in_ready}); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(4'b0001, 32'h1, 32'h2, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h3, 4'b0000}) begin nerr++; $display("FAIL bp_first: got %h want %h", obs, {1'b1, 32'h3, 4'b0000}); end
      drive(4'b0110, 32'h5, 32'h3, 5'd0);
      for (int i = 0; i < 3; i++) begin
         nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
         tick();
         nchk++; if (obs !== {1'b1, 32'h3, 4'b0000}) begin nerr++; $display("FAIL bp_hold: got %h want %h", obs, {1'b1, 32'h3, 4'b0000}); end
      end
      out_ready = 1'b1; #1;
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
      tick();
      nchk++; if (obs !== {1'b1, 32'h2, 4'b0010}) begin nerr++; $display("FAIL bp_second: got %h want %h", obs, {1'b1, 32'h2, 4'b0010}); end
      drive(4'b0011, 32'h6, 32'h3, 5'd0); tick();
      nchk++; if (obs !== {1'b1, 32'h5, 4'b0000}) begin nerr++; $display("FAIL bp_third: got %h want %h", obs, {1'b1, 32'h5, 4'b0000}); end
      in_valid = 1'b0; tick();
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
   endtask

   task automatic test_mul();
      drive(4'b0111, 32'h0001_0000, 32'h0001_0001, 5'd0); tick();
      in_valid = 1'b0;
`ifdef ALU_PIPE_MUL_EN
      nchk++; if ({out_valid, busy, in_ready} !== 3'b010) begin nerr++; $display("FAIL mul_start: got %b want 010", {out_valid, busy, in_ready}); end
      for (int i = 1; i < W; i++) begin
         tick();
         nchk++; if ({out_valid, busy} !== 2'b01) begin nerr++; $display("FAIL mul_wait%0d: got %b want 01", i, {out_valid, busy}); end
      end
      tick();
      nchk++; if (obs !== {1'b1, 32'h0001_0000, 4'b0010}) begin nerr++; $display("FAIL mul_result: got %h want %h", obs, {1'b1, 32'h0001_0000, 4'b0010}); end
      nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL mul_busy_end: got %b want 0", busy); end
`else
      nchk++; if (obs !== {1'b1, 32'h0001_0000, 4'b0000}) begin nerr++; $display("FAIL op7_pass: got %h want %h", obs, {1'b1, 32'h0001_0000, 4'b0000}); end
      nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL op7_busy: got %b want 0", busy); end
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(4'b0111, 32'd7, 32'd9, 5'd0); tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0; #1;
      nchk++; if (obs !== {1'b0, 32'h0, 4'b0000}) begin nerr++; $display("FAIL rst_mid_out: got %h want %h", obs, {1'b0, 32'h0, 4'b0000}); end
      nchk++; if ({in_ready, busy} !== 2'b10) begin nerr++; $display("FAIL rst_mid_rdy: got %b want 10", {in_ready, busy}); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         nchk++; if ({out_valid, busy} !== 2'b00) begin nerr++; $display("FAIL rst_mid_idle%0d: got %b want 00", i, {out_valid, busy}); end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_back_to_back();
      test_backpressure();
      test_mul();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
